updn_ctr_bnd: RTL and testbench

//   Parametrised up/down counter with programmable lower/upper bounds, step size
//   and wrap-or-saturate mode. Successor to the fixed-range DW03-style up/down

---
 rtl/updn_ctr_bnd.sv | 101 ++++++++++
 tb/tb_updn_ctr_bnd.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/updn_ctr_bnd.sv
// Bounded up/down counter with step, wrap-or-saturate mode,
// boundary event pulse and sticky configuration-error flag.
module updn_ctr_bnd #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             cen,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic             tercnt,
    output logic             bnd_evt,
    output logic             err
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             bnd_evt_q, bnd_evt_d;
    logic             err_q, err_d;

    logic             cfg_bad;
    logic             in_rng;
    logic [WIDTH:0]   up_nxt;
    logic [WIDTH:0]   lo_plus;
    logic [WIDTH-1:0] span_w;
    logic [WIDTH-1:0] clamped;

    assign cfg_bad = (lo > hi) || (step > (hi - lo));
    assign in_rng  = (count_q >= lo) && (count_q <= hi);
    assign up_nxt  = {1'b0, count_q} + {1'b0, step};
    assign lo_plus = {1'b0, lo} + {1'b0, step};
    // Modular W-bit span is exact because wrapped results land in [lo,hi]
    assign span_w  = hi - lo + 1'b1;

    always_comb begin
        clamped = data;
        if (lo <= hi) begin
            if (data < lo)
                clamped = lo;
            else if (data > hi)
                clamped = hi;
        end
    end

    always_comb begin
        count_d   = count_q;
        bnd_evt_d = 1'b0;
        err_d     = err_q;
        if (!load) begin
            count_d = clamped;
            err_d   = 1'b0;
        end else if (cen) begin
            if (cfg_bad) begin
                err_d = 1'b1;
            end else if (!in_rng) begin
                count_d   = up_dn ? lo : hi;
                bnd_evt_d = 1'b1;
            end else if (step == '0) begin
                count_d = count_q;
            end else if (up_dn) begin
                if (up_nxt <= {1'b0, hi}) begin
                    count_d = up_nxt[WIDTH-1:0];
                end else begin
                    count_d   = sat ? hi : (count_q + step - span_w);
                    bnd_evt_d = 1'b1;
                end
            end else begin
                if ({1'b0, count_q} >= lo_plus) begin
                    count_d = count_q - step;
                end else begin
                    count_d   = sat ? lo : (count_q - step + span_w);
                    bnd_evt_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= RST_VAL;
            bnd_evt_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            bnd_evt_q <= bnd_evt_d;
            err_q     <= err_d;
        end
    end

    assign count   = count_q;
    assign bnd_evt = bnd_evt_q;
    assign err     = err_q;
    assign tercnt  = (up_dn && (count_q == hi)) || (!up_dn && (count_q == lo));

endmodule

// File: tb/tb_updn_ctr_bnd.sv
// Directed bench for updn_ctr_bnd, WIDTH=4, RST_VAL=0.
// Expected values are hand-computed constants per step.
module tb_updn_ctr_bnd;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] data;
    logic       cen;
    logic       up_dn;
    logic [3:0] step;
    logic [3:0] lo;
    logic [3:0] hi;
    logic       sat;
    logic [3:0] count;
    logic       tercnt;
    logic       bnd_evt;
    logic       err;

    int vecs = 0;
    int errs = 0;

    updn_ctr_bnd #(.WIDTH(4), .RST_VAL(4'd0)) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .data   (data),
        .cen    (cen),
        .up_dn  (up_dn),
        .step   (step),
        .lo     (lo),
        .hi     (hi),
        .sat    (sat),
        .count  (count),
        .tercnt (tercnt),
        .bnd_evt(bnd_evt),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] d);
        load = 1'b0;
        cen  = 1'b0;
        data = d;
        tick();
        load = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        load  = 1'b1;
        data  = 4'd0;
        cen   = 1'b0;
        up_dn = 1'b1;
        step  = 4'd1;
        lo    = 4'd0;
        hi    = 4'd15;
        sat   = 1'b0;
        #12;
        chk("rst_count", {4'd0, count}, 8'd0);
        chk("rst_evt", {7'd0, bnd_evt}, 8'd0);
        chk("rst_err", {7'd0, err}, 8'd0);
        reset = 1'b1;

        // 1: async reset mid-cycle
        do_load(4'd9);
        chk("t1_load9", {4'd0, count}, 8'd9);
        cen = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        chk("t1_async_cnt", {4'd0, count}, 8'd0);
        chk("t1_async_evt", {7'd0, bnd_evt}, 8'd0);
        chk("t1_async_err", {7'd0, err}, 8'd0);
        tick();
        chk("t1_held", {4'd0, count}, 8'd0);
        #3;
        reset = 1'b1;
        cen   = 1'b0;

        // 2: load clamp
        lo = 4'd2;
        hi = 4'd12;
        do_load(4'd7);
        chk("t2_d7", {4'd0, count}, 8'd7);
        do_load(4'd14);
        chk("t2_d14", {4'd0, count}, 8'd12);
        do_load(4'd1);
        chk("t2_d1", {4'd0, count}, 8'd2);
        load  = 1'b0;
        cen   = 1'b1;
        data  = 4'd7;
        step  = 4'd3;
        up_dn = 1'b1;
        tick();
        chk("t2_ld_wins", {4'd0, count}, 8'd7);
        load = 1'b1;

        // 3: up wrap then saturate
        do_load(4'd11);
        sat = 1'b0;
        cen = 1'b1;
        tick();
        chk("t3_wrap", {4'd0, count}, 8'd3);
        chk("t3_wrap_evt", {7'd0, bnd_evt}, 8'd1);
        tick();
        chk("t3_step6", {4'd0, count}, 8'd6);
        chk("t3_evt_gone", {7'd0, bnd_evt}, 8'd0);
        do_load(4'd11);
        sat = 1'b1;
        cen = 1'b1;
        tick();
        chk("t3_sat", {4'd0, count}, 8'd12);
        chk("t3_sat_evt", {7'd0, bnd_evt}, 8'd1);
        chk("t3_tercnt", {7'd0, tercnt}, 8'd1);
        tick();
        chk("t3_sat_hold", {4'd0, count}, 8'd12);
        chk("t3_sat_evt2", {7'd0, bnd_evt}, 8'd1);

        // 4: down wrap and exact reach of lo
        do_load(4'd3);
        chk("t4_idle_evt", {7'd0, bnd_evt}, 8'd0);
        sat   = 1'b0;
        up_dn = 1'b0;
        cen   = 1'b1;
        tick();
        chk("t4_dwrap", {4'd0, count}, 8'd11);
        chk("t4_dwrap_evt", {7'd0, bnd_evt}, 8'd1);
        do_load(4'd5);
        cen = 1'b1;
        tick();
        chk("t4_to_lo", {4'd0, count}, 8'd2);
        chk("t4_to_lo_evt", {7'd0, bnd_evt}, 8'd0);
        chk("t4_tercnt", {7'd0, tercnt}, 8'd1);

        // 5: config error
        cen   = 1'b0;
        up_dn = 1'b1;
        step  = 4'd10;
        do_load(4'd2);
        cen = 1'b1;
        tick();
        chk("t5_step_max_ok", {4'd0, count}, 8'd12);
        chk("t5_step_max_err", {7'd0, err}, 8'd0);
        chk("t5_step_max_evt", {7'd0, bnd_evt}, 8'd0);
        do_load(4'd2);
        step = 4'd11;
        cen  = 1'b1;
        tick();
        chk("t5_bad_hold", {4'd0, count}, 8'd2);
        chk("t5_bad_err", {7'd0, err}, 8'd1);
        step = 4'd1;
        tick();
        chk("t5_sticky_cnt", {4'd0, count}, 8'd3);
        chk("t5_sticky_err", {7'd0, err}, 8'd1);
        do_load(4'd5);
        chk("t5_clr_err", {7'd0, err}, 8'd0);
        chk("t5_clr_cnt", {4'd0, count}, 8'd5);
        lo  = 4'd9;
        hi  = 4'd4;
        cen = 1'b1;
        tick();
        chk("t5_inv_err", {7'd0, err}, 8'd1);
        chk("t5_inv_hold", {4'd0, count}, 8'd5);

        // 6: out-of-range recovery and combinational tercnt
        lo = 4'd2;
        hi = 4'd12;
        do_load(4'd7);
        lo    = 4'd8;
        hi    = 4'd15;
        step  = 4'd1;
        up_dn = 1'b1;
        cen   = 1'b1;
        tick();
        chk("t6_oor_cnt", {4'd0, count}, 8'd8);
        chk("t6_oor_evt", {7'd0, bnd_evt}, 8'd1);
        cen = 1'b0;
        #1;
        chk("t6_ter_up", {7'd0, tercnt}, 8'd0);
        up_dn = 1'b0;
        #1;
        chk("t6_ter_dn", {7'd0, tercnt}, 8'd1);
        tick();
        chk("t6_hold_cnt", {4'd0, count}, 8'd8);
        chk("t6_hold_evt", {7'd0, bnd_evt}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
